// File: rtl/if_stage.sv
// if_stage: instruction fetch with a single outstanding memory request,
// a one-entry skid buffer behind IF/ID, and HLT/branch run control.
module if_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch,
    input  logic [15:0] branch_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc,
    output logic [15:0] ifid_pc_plus2,
    output logic        ifid_valid,
    output logic        halted
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] pc;
    logic [15:0] req_pc;
    logic [15:0] buf_instr;
    logic [15:0] buf_pc;
    logic        outst;
    logic        discard;
    logic        buf_valid;
    logic        resp;
    logic        keep;
    logic        is_hlt;

    assign resp   = imem_valid & outst;
    assign keep   = resp & ~discard & ~branch;
    assign is_hlt = (imem_rdata[15:12] == 4'hF);

    assign imem_addr     = pc;
    assign ifid_pc_plus2 = ifid_pc + 16'd2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (1'b1)
            branch:          state_next = RUN;
            (keep && is_hlt): state_next = HALT;
            default:         state_next = state;
        endcase
    end

    always_comb begin
        halted   = (state == HALT);
        imem_req = (state == RUN) & ~rst & ~outst & ~buf_valid
                 & ~stall & ~branch;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            req_pc     <= '0;
            outst      <= 1'b0;
            discard    <= 1'b0;
            buf_valid  <= 1'b0;
            buf_instr  <= '0;
            buf_pc     <= '0;
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
            ifid_pc    <= '0;
        end else if (branch) begin
            // A request still in flight stays counted and is squashed on return.
            pc         <= branch_target;
            outst      <= outst & ~imem_valid;
            discard    <= outst & ~imem_valid;
            buf_valid  <= 1'b0;
            ifid_valid <= 1'b0;
        end else begin
            if (imem_req) begin
                outst  <= 1'b1;
                req_pc <= pc;
                pc     <= pc + 16'd2;
            end else if (resp) begin
                outst   <= 1'b0;
                discard <= 1'b0;
            end

            if (keep && !stall) begin
                ifid_instr <= imem_rdata;
                ifid_pc    <= req_pc;
                ifid_valid <= 1'b1;
            end else if (keep) begin
                buf_valid <= 1'b1;
                buf_instr <= imem_rdata;
                buf_pc    <= req_pc;
            end else if (!stall && buf_valid) begin
                ifid_instr <= buf_instr;
                ifid_pc    <= buf_pc;
                ifid_valid <= 1'b1;
                buf_valid  <= 1'b0;
            end else if (!stall) begin
                ifid_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scoreboard bench for if_stage with a variable-latency
// instruction memory model driven from the test tasks.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = 16'h0000;
    logic        imem_valid = 1'b0;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic [15:0] ifid_pc_plus2;
    logic        ifid_valid;
    logic        halted;

    if_stage #(.RESET_PC(16'h0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch       (branch),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_valid   (imem_valid),
        .ifid_instr   (ifid_instr),
        .ifid_pc      (ifid_pc),
        .ifid_pc_plus2(ifid_pc_plus2),
        .ifid_valid   (ifid_valid),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          lat = 1;
    int          cnt = 0;
    bit          pend = 1'b0;
    logic [15:0] pend_addr = 16'h0000;
    bit          prev_stall = 1'b0;
    bit          hlt_en = 1'b0;

    function automatic logic [15:0] memword(input logic [15:0] a);
        if (hlt_en && a == 16'h0010) return 16'hF000;
        return {4'hA, a[12:1]};
    endfunction

    // One clock: memory model plus IF/ID scoreboard.
    task automatic tick();
        exp_t e;
        #1;
        if (imem_req === 1'b1) begin
            pend = 1'b1;
            cnt = lat;
            pend_addr = imem_addr;
        end
        prev_stall = stall;
        @(posedge clk);
        #1;
        imem_valid = 1'b0;
        imem_rdata = 16'h5A5A;
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                pend = 1'b0;
                imem_valid = 1'b1;
                imem_rdata = memword(pend_addr);
            end
        end
        if (ifid_valid === 1'b1 && !prev_stall) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got pc %h instr %h want none", ifid_pc, ifid_instr);
            end else begin
                e = exp_q.pop_front();
                if (ifid_pc !== e.pc || ifid_instr !== e.instr ||
                    ifid_pc_plus2 !== e.pc + 16'd2) begin
                    errors++;
                    $display("FAIL sb_load got %h/%h/%h want %h/%h/%h", ifid_pc, ifid_instr,
                             ifid_pc_plus2, e.pc, e.instr, e.pc + 16'd2);
                end
            end
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        stall = 1'b0;
        branch = 1'b0;
        exp_q.delete();
        repeat (n) tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        lat = 1;
        rst = 1'b1;
        tick();
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", imem_req); end
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", ifid_valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b want 0", halted); end
        checks++; if (ifid_pc !== 16'h0) begin errors++; $display("FAIL rst_pc got %h want 0000", ifid_pc); end
        checks++; if (ifid_instr !== 16'h0) begin errors++; $display("FAIL rst_instr got %h want 0000", ifid_instr); end
        checks++; if (imem_addr !== 16'h0) begin errors++; $display("FAIL rst_addr got %h want 0000", imem_addr); end
    endtask

    task automatic test_straight();
        lat = 1;
        do_reset(2);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL st_req0 got %b/%h want 1/0000", imem_req, imem_addr); end
        exp_q.push_back('{pc: 16'h0000, instr: 16'hA000});
        exp_q.push_back('{pc: 16'h0002, instr: 16'hA001});
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL st_busy got %b want 0", imem_req); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0002) begin errors++; $display("FAIL st_req1 got %b/%h want 1/0002", imem_req, imem_addr); end
        tick();
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL st_bubble got %b want 0", ifid_valid); end
        tick();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL st_left got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_stall();
        lat = 1;
        do_reset(2);
        exp_q.push_back('{pc: 16'h0000, instr: 16'hA000});
        exp_q.push_back('{pc: 16'h0002, instr: 16'hA001});
        tick();
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0002) begin errors++; $display("FAIL sk_req1 got %b/%h want 1/0002", imem_req, imem_addr); end
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL sk_hold%0d got %b want 0", i, ifid_valid); end
        end
        stall = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL sk_bufblk got %b want 0", imem_req); end
        tick();
        checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL sk_drain got %b want 1", ifid_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0004) begin errors++; $display("FAIL sk_next got %b/%h want 1/0004", imem_req, imem_addr); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sk_left got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_branch();
        lat = 3;
        do_reset(3);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL br_req0 got %b/%h want 1/0000", imem_req, imem_addr); end
        tick();
        branch = 1'b1;
        branch_target = 16'h0040;
        tick();
        branch = 1'b0;
        #1;
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL br_valid got %b want 0", ifid_valid); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL br_wait got %b want 0", imem_req); end
        tick();
        tick();
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL br_drop got %b want 0", ifid_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin errors++; $display("FAIL br_tgt got %b/%h want 1/0040", imem_req, imem_addr); end
        exp_q.push_back('{pc: 16'h0040, instr: 16'hA020});
        repeat (4) tick();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL br_left got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_halt();
        lat = 1;
        hlt_en = 1'b1;
        do_reset(2);
        branch = 1'b1;
        branch_target = 16'h0010;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ht_brblk got %b want 0", imem_req); end
        tick();
        branch = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0010) begin errors++; $display("FAIL ht_req got %b/%h want 1/0010", imem_req, imem_addr); end
        exp_q.push_back('{pc: 16'h0010, instr: 16'hF000});
        tick();
        tick();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL ht_enter got %b want 1", halted); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ht_noreq%0d got %b want 0", i, imem_req); end
            tick();
        end
        branch = 1'b1;
        branch_target = 16'h0020;
        tick();
        branch = 1'b0;
        #1;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL ht_exit got %b want 0", halted); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0020) begin errors++; $display("FAIL ht_resume got %b/%h want 1/0020", imem_req, imem_addr); end
        exp_q.push_back('{pc: 16'h0020, instr: 16'hA010});
        tick();
        tick();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ht_left got %0d want 0", exp_q.size()); end
        hlt_en = 1'b0;
    endtask

    task automatic test_wrap();
        lat = 1;
        do_reset(2);
        branch = 1'b1;
        branch_target = 16'hFFFE;
        tick();
        branch = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'hFFFE) begin errors++; $display("FAIL wr_req got %b/%h want 1/FFFE", imem_req, imem_addr); end
        exp_q.push_back('{pc: 16'hFFFE, instr: 16'hAFFF});
        tick();
        tick();
        checks++; if (ifid_pc_plus2 !== 16'h0000) begin errors++; $display("FAIL wr_plus2 got %h want 0000", ifid_pc_plus2); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL wr_next got %b/%h want 1/0000", imem_req, imem_addr); end
        exp_q.push_back('{pc: 16'h0000, instr: 16'hA000});
        tick();
        tick();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wr_left got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_reset_inflight();
        lat = 2;
        do_reset(2);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL ri_req0 got %b/%h want 1/0000", imem_req, imem_addr); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (imem_valid !== 1'b1) begin errors++; $display("FAIL ri_stale got %b want 1", imem_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL ri_first got %b/%h want 1/0000", imem_req, imem_addr); end
        tick();
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL ri_ignore got %b want 0", ifid_valid); end
        exp_q.push_back('{pc: 16'h0000, instr: 16'hA000});
        tick();
        tick();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ri_left got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_straight();
        test_stall();
        test_branch();
        test_halt();
        test_wrap();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
